// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, MS->WS field layout and load-op codes.
// The packed structs follow the bus order MSB->LSB so they can be assigned to/from the raw buses.
package mem_stage_pkg;

    localparam int unsigned MS_TO_WS_BUS_WD = 149;
    localparam int unsigned ES_TO_MS_BUS_WD = 153;

    // Bit positions inside the raw ES->MS bus
    localparam int unsigned ES_MEM_REQ_BIT  = 149;
    localparam int unsigned ES_EX_BIT       = 75;

    typedef enum logic [2:0] {
        LoadW  = 3'd0,
        LoadB  = 3'd1,
        LoadBu = 3'd2,
        LoadH  = 3'd3,
        LoadHu = 3'd4
    } load_op_e;

    typedef struct packed {
        logic [31:0] rt_value;
        logic        eret;
        logic        bd;
        logic        mtc0_we;
        logic [4:0]  cp0_addr;
        logic        res_from_cp0;
        logic [31:0] badvaddr;
        logic        ex;
        logic [4:0]  excode;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } ms_to_ws_t;

    typedef struct packed {
        logic [2:0] load_op;
        logic       mem_req;
        ms_to_ws_t  ms;
    } es_to_ms_t;

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data aligner: picks the addressed byte/half of the read word and extends it.
// Unknown load-op codes fall back to a full-word load.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  i_load_op,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    // Halfword loads ignore addr[0]; misalignment is trapped upstream
    assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_result = i_rdata;
        case (i_load_op)
            LoadB:   o_result = sext8(w_byte);
            LoadBu:  o_result = {24'd0, w_byte};
            LoadH:   o_result = sext16(w_half);
            LoadHu:  o_result = {16'd0, w_half};
            default: o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds the EX payload, waits for the data-SRAM response of a load/store,
// aligns load data and feeds WB, ID forwarding, and drops responses orphaned by WB flushes.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    input  logic                       es_mem_req_fire,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       ws_ex,
    output logic                       ms_ex_or_eret,
    output logic                       ms_fwd_we,
    output logic [4:0]                 ms_fwd_dest,
    output logic [31:0]                ms_fwd_data,
    output logic                       ms_fwd_blocked
);

    es_to_ms_t   r_payload;
    logic        r_ms_valid;
    logic        r_wait_resp;
    logic        r_buf_valid;
    logic [31:0] r_data_buf;
    logic [1:0]  r_drop_cnt;

    logic        w_drop_resp;
    logic        w_resp_ok;
    logic        w_ready_go;
    logic        w_accept;
    logic        w_handoff;
    logic        w_in_wait;
    logic        w_is_load;
    logic [31:0] w_aligned;
    logic [31:0] w_final_result;
    logic [1:0]  w_drop_inc;
    logic [2:0]  w_drop_sum;
    logic [1:0]  w_drop_next;
    ms_to_ws_t   w_out;

    // A response is consumed by MS only when no orphaned responses are still in flight
    assign w_drop_resp = data_sram_data_ok && (r_drop_cnt != 2'd0);
    assign w_resp_ok   = data_sram_data_ok && (r_drop_cnt == 2'd0) && r_wait_resp;

    assign w_ready_go     = !r_wait_resp || w_resp_ok || r_buf_valid;
    assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid && w_ready_go;

    assign w_accept  = es_to_ms_valid && ms_allowin && !ws_ex;
    assign w_handoff = ms_to_ws_valid && ws_allowin;
    assign w_in_wait = es_to_ms_bus[ES_MEM_REQ_BIT] && !es_to_ms_bus[ES_EX_BIT];
    assign w_is_load = r_payload.mem_req && r_payload.ms.gr_we && !r_payload.ms.ex;

    mem_stage_load_align u_load_align (
        .i_load_op (r_payload.load_op),
        .i_addr    (r_payload.ms.result[1:0]),
        .i_rdata   (data_sram_rdata),
        .o_result  (w_aligned)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ms_valid <= 1'b0;
        end else if (ws_ex) begin
            r_ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            r_ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_payload <= es_to_ms_bus;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wait_resp <= 1'b0;
        end else if (ws_ex) begin
            r_wait_resp <= 1'b0;
        end else if (w_accept) begin
            r_wait_resp <= w_in_wait;
        end else if (w_resp_ok) begin
            r_wait_resp <= 1'b0;
        end
    end

    // Response arrived but WB is stalled: park the aligned word until handoff
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_buf_valid <= 1'b0;
            r_data_buf  <= 32'd0;
        end else if (ws_ex || w_handoff) begin
            r_buf_valid <= 1'b0;
        end else if (w_resp_ok && !ws_allowin) begin
            r_buf_valid <= 1'b1;
            r_data_buf  <= w_aligned;
        end
    end

    always_comb begin
        w_drop_inc = 2'd0;
        if (ws_ex) begin
            w_drop_inc = {1'b0, r_ms_valid && r_wait_resp && !w_resp_ok}
                       + {1'b0, es_mem_req_fire};
        end
        w_drop_sum  = {1'b0, r_drop_cnt} + {1'b0, w_drop_inc} - {2'b00, w_drop_resp};
        w_drop_next = (w_drop_sum > 3'd2) ? 2'd2 : w_drop_sum[1:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_drop_cnt <= 2'd0;
        end else begin
            r_drop_cnt <= w_drop_next;
        end
    end

    always_comb begin
        w_final_result = r_payload.ms.result;
        if (w_is_load) begin
            if (r_buf_valid) begin
                w_final_result = r_data_buf;
            end else if (w_resp_ok) begin
                w_final_result = w_aligned;
            end
        end
    end

    always_comb begin
        w_out        = r_payload.ms;
        w_out.result = w_final_result;
    end

    assign ms_to_ws_bus   = w_out;
    assign ms_ex_or_eret  = r_ms_valid && (r_payload.ms.ex || r_payload.ms.eret);
    assign ms_fwd_we      = r_ms_valid && r_payload.ms.gr_we;
    assign ms_fwd_dest    = r_ms_valid ? r_payload.ms.dest : 5'd0;
    assign ms_fwd_data    = r_ms_valid ? w_final_result : 32'd0;
    assign ms_fwd_blocked = r_ms_valid && w_is_load && r_wait_resp && !w_resp_ok;

    a_drop_cnt_max: assert property (@(posedge clk) disable iff (!resetn)
        r_drop_cnt != 2'd3);
    a_buf_no_wait: assert property (@(posedge clk) disable iff (!resetn)
        !(r_buf_valid && r_wait_resp));

endmodule
